// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_if
// Description : Signal bundle between two requesters, the shared-multiplier
//               arbiter and the multiplier itself.
//               slave  - arbiter view (takes requests, drives the multiplier)
//               master - environment view (requesters and multiplier)
//               Requester side : req0/req1, a0/b0/a1/b1 -> ack0/ack1,
//                                rvalid, rid, result, err, busy
//               Multiplier side: m_start, m_a, m_b -> m_done, m_product
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                   req0;
    logic                   req1;
    logic [WIDTH-1:0]       a0;
    logic [WIDTH-1:0]       b0;
    logic [WIDTH-1:0]       a1;
    logic [WIDTH-1:0]       b1;
    logic                   ack0;
    logic                   ack1;
    logic                   rvalid;
    logic                   rid;
    logic [2*WIDTH-1:0]     result;
    logic                   err;
    logic                   busy;
    logic                   m_start;
    logic [WIDTH-1:0]       m_a;
    logic [WIDTH-1:0]       m_b;
    logic                   m_done;
    logic [2*WIDTH-1:0]     m_product;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, m_done, m_product,
        output ack0, ack1, rvalid, rid, result, err, busy, m_start, m_a, m_b
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, m_done, m_product,
        input  ack0, ack1, rvalid, rid, result, err, busy, m_start, m_a, m_b
    );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter granting two requesters access to one
//               shared multi-cycle multiplier, with a WAIT-state timeout.
//               Flow per transaction: IDLE (grant + ack) -> ISSUE (m_start)
//               -> WAIT (until m_done or timeout) -> RESP (rvalid) -> IDLE.
// Ports       : clk    - single clock, rising edge
//               reset  - synchronous, active-low
//               bus    - mult_arbiter_if.slave: requests/operands in,
//                        ack/response out, multiplier start/operands out,
//                        multiplier done/product in
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mult_arbiter_if.slave   bus
);

    // Counter only has to reach TIMEOUT-1.
    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_last_gnt;     // requester granted most recently
    logic                   r_pend_rid;     // requester of the in-flight transaction
    logic [WIDTH-1:0]       r_m_a;
    logic [WIDTH-1:0]       r_m_b;
    logic                   r_rid;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_err;
    logic [c_CNT_W-1:0]     r_cnt;

    logic                   w_any;
    logic                   w_win;
    logic                   w_cnt_last;
    logic                   w_ack0;
    logic                   w_ack1;
    logic                   w_m_start;
    logic                   w_rvalid;
    logic                   w_busy;

    // ------------------------------------------------------------------------
    // Arbitration: a lone request wins outright; on a tie the requester that
    // was not granted last time wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any      = bus.req0 | bus.req1;
        w_win      = (bus.req0 && bus.req1) ? ~r_last_gnt : bus.req1;
        w_cnt_last = (r_cnt == c_CNT_LAST);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        w_m_start    = 1'b0;
        w_rvalid     = 1'b0;
        w_busy       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_ISSUE;
                    w_ack0       = ~w_win;
                    w_ack1       = w_win;
                end
            end
            S_ISSUE: begin
                w_busy       = 1'b1;
                w_m_start    = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (bus.m_done || w_cnt_last) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_busy       = 1'b1;
                w_rvalid     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Combinational strobes stay quiet while reset is held, so a pulse
        // can never be seen in the cycle a transaction is being aborted.
        if (!reset) begin
            w_ack0    = 1'b0;
            w_ack1    = 1'b0;
            w_m_start = 1'b0;
            w_rvalid  = 1'b0;
            w_busy    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch, timeout counter, response registers.
    // rid/result/err are only written on the WAIT->RESP edge so they hold
    // the last response until the next one replaces it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_gnt <= 1'b1;             // requester 0 wins the first tie
            r_pend_rid <= 1'b0;
            r_m_a      <= '0;
            r_m_b      <= '0;
            r_rid      <= 1'b0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_m_a      <= w_win ? bus.a1 : bus.a0;
                        r_m_b      <= w_win ? bus.b1 : bus.b0;
                        r_pend_rid <= w_win;
                        r_last_gnt <= w_win;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // m_done takes precedence over a coincident timeout.
                    if (bus.m_done) begin
                        r_result <= bus.m_product;
                        r_err    <= 1'b0;
                        r_rid    <= r_pend_rid;
                    end else if (w_cnt_last) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_rid    <= r_pend_rid;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.ack0    = w_ack0;
    assign bus.ack1    = w_ack1;
    assign bus.m_start = w_m_start;
    assign bus.rvalid  = w_rvalid;
    assign bus.busy    = w_busy;
    assign bus.m_a     = r_m_a;
    assign bus.m_b     = r_m_b;
    assign bus.rid     = r_rid;
    assign bus.result  = r_result;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter. A transaction-level
//               reference model predicts grants, pulse timing and responses;
//               a behavioural multiplier answers m_start after a chosen delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int c_WIDTH   = 8;
    localparam int c_TIMEOUT = 64;
    localparam int c_NEVER   = 100000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(c_WIDTH)) bus ();

    mult_arbiter #(
        .WIDTH   (c_WIDTH),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // multiplier environment
    int          cur_delay  = 1;
    bit          spurious   = 1'b0;
    int          done_cycle = -1;
    logic [15:0] mprod      = '0;

    // reference model state
    bit          inflight   = 1'b0;
    bit          last       = 1'b1;
    int          ack_cyc    = 0;
    int          rv_cyc     = 0;
    bit          exp_id     = 1'b0;
    logic [7:0]  exp_a      = '0;
    logic [7:0]  exp_b      = '0;
    logic [15:0] exp_res    = '0;
    bit          exp_err    = 1'b0;
    bit          hold_known = 1'b0;
    bit          hold_rid   = 1'b0;
    logic [15:0] hold_res   = '0;
    bit          hold_err   = 1'b0;

    // raw DUT observations of the last stepped cycle
    bit          dut_ack    = 1'b0;
    bit          dut_ack_id = 1'b0;
    bit          dut_rv     = 1'b0;
    int          obs_cyc    = 0;

    typedef struct {
        bit          r0;
        bit          r1;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        int          d;
        bit          rid;
        logic [15:0] res;
        bit          err;
    } vec_t;

    vec_t        tbl [8];
    int          order [$];
    logic [15:0] rs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: inputs are already set; compare at the falling edge,
    // drive the multiplier for this cycle, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        obs_cyc    = cyc;
        dut_ack    = bus.ack0 | bus.ack1;
        dut_ack_id = bus.ack1;
        dut_rv     = bus.rvalid;
        if (!reset) begin
            check("reset_strobes", {bus.ack0, bus.ack1, bus.rvalid, bus.m_start, bus.busy}, 5'b0);
            inflight   = 1'b0;
            last       = 1'b1;
            hold_known = 1'b1;
            hold_rid   = 1'b0;
            hold_res   = '0;
            hold_err   = 1'b0;
        end else begin
            bit want_ack;
            bit win;
            want_ack = !inflight && (bus.req0 || bus.req1);
            win      = (bus.req0 && bus.req1) ? !last : bus.req1;
            check("ack", {bus.ack0, bus.ack1}, want_ack ? (win ? 2'b01 : 2'b10) : 2'b00);
            check("busy", bus.busy, inflight);
            check("m_start", bus.m_start, inflight && (cyc == ack_cyc + 1));
            if (inflight)
                check("m_operands", {bus.m_a, bus.m_b}, {exp_a, exp_b});
            check("rvalid", bus.rvalid, inflight && (cyc == rv_cyc));
            if (inflight && (cyc == rv_cyc)) begin
                check("response", {bus.rid, bus.result, bus.err}, {exp_id, exp_res, exp_err});
                hold_known = 1'b1;
                hold_rid   = exp_id;
                hold_res   = exp_res;
                hold_err   = exp_err;
                inflight   = 1'b0;
            end else if (hold_known) begin
                check("held_response", {bus.rid, bus.result, bus.err}, {hold_rid, hold_res, hold_err});
            end
            if (want_ack) begin
                inflight = 1'b1;
                ack_cyc  = cyc;
                last     = win;
                exp_id   = win;
                exp_a    = win ? bus.a1 : bus.a0;
                exp_b    = win ? bus.b1 : bus.b0;
                if (cur_delay <= c_TIMEOUT) begin
                    exp_res = 16'(exp_a) * 16'(exp_b);
                    exp_err = 1'b0;
                    rv_cyc  = cyc + 1 + cur_delay + 1;
                end else begin
                    exp_res = '0;
                    exp_err = 1'b1;
                    rv_cyc  = cyc + 1 + c_TIMEOUT + 1;
                end
            end
        end
        // behavioural multiplier (does not see the arbiter's reset)
        if (bus.m_start) begin
            done_cycle = cyc + cur_delay;
            mprod      = 16'(bus.m_a) * 16'(bus.m_b);
        end
        bus.m_done    = (cyc == done_cycle) || spurious;
        bus.m_product = (cyc == done_cycle) ? mprod : 16'hBEEF;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Step until a response; optionally drop requests once acked.
    task automatic run_txn(input bit drop, output int lat);
        int  acyc;
        bit  got;
        acyc = 0;
        got  = 1'b0;
        lat  = -1;
        for (int n = 0; n < 300; n++) begin
            step();
            if (dut_ack && !got) begin
                got  = 1'b1;
                acyc = obs_cyc;
                if (drop) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
            if (dut_rv) begin
                lat = obs_cyc - acyc;
                return;
            end
        end
        bound_fail("txn_response");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int          lat;
        bit          s_rid;
        logic [15:0] s_res;
        bit          s_err;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.m_done = 1'b0; bus.m_product = '0;

        //          r0 r1  a0   b0   a1   b1   d    rid  res    err
        tbl[0] = '{1'b1, 1'b0, 8'd12,  8'd11, 8'd0,   8'd0,   10, 1'b0, 16'd132,   1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'd0,   8'd0,  8'd255, 8'd255, 3,  1'b1, 16'd65025, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'd3,   8'd5,  8'd7,   8'd9,   1,  1'b0, 16'd15,    1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'd3,   8'd5,  8'd7,   8'd9,   2,  1'b1, 16'd63,    1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'd200, 8'd2,  8'd0,   8'd0,   64, 1'b0, 16'd400,   1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'd0,   8'd0,  8'd17,  8'd19,  65, 1'b1, 16'd0,     1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'd0,   8'd0,  8'd16,  8'd16,  2,  1'b1, 16'd256,   1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'd1,   8'd1,  8'd2,   8'd2,   5,  1'b0, 16'd1,     1'b0};

        do_reset();
        check("reset_values", {bus.rid, bus.result, bus.err, bus.m_a, bus.m_b, bus.busy}, '0);

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < 8; i++) begin
            bus.req0 = tbl[i].r0; bus.req1 = tbl[i].r1;
            bus.a0 = tbl[i].a0; bus.b0 = tbl[i].b0;
            bus.a1 = tbl[i].a1; bus.b1 = tbl[i].b1;
            cur_delay = tbl[i].d;
            run_txn(1'b1, lat);
            check("tbl_rid", bus.rid, tbl[i].rid);
            check("tbl_result", bus.result, tbl[i].res);
            check("tbl_err", bus.err, tbl[i].err);
            check("tbl_latency", lat, (tbl[i].d <= c_TIMEOUT) ? tbl[i].d + 2 : c_TIMEOUT + 2);
        end

        // ---------------- both requesters held: alternating grants ----------------
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.a0 = 8'd3; bus.b0 = 8'd5; bus.a1 = 8'd7; bus.b1 = 8'd9;
        cur_delay = 2;
        for (int n = 0; n < 200 && rs.size() < 4; n++) begin
            step();
            if (dut_ack) order.push_back(int'(dut_ack_id));
            if (dut_rv) rs.push_back(bus.result);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        if (rs.size() < 4) bound_fail("rr_responses");
        check("rr_grant_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++)
            check("rr_grant_order", order[i], i % 2);
        for (int i = 0; i < rs.size(); i++)
            check("rr_result", rs[i], (i % 2 == 0) ? 16'd15 : 16'd63);
        step();

        // ---------------- multiplier never answers: timeout ----------------
        bus.req0 = 1'b1; bus.a0 = 8'd5; bus.b0 = 8'd6;
        cur_delay = c_NEVER;
        run_txn(1'b1, lat);
        check("timeout_latency", lat, c_TIMEOUT + 2);
        check("timeout_err", bus.err, 1'b1);
        check("timeout_result", bus.result, 16'd0);
        check("timeout_busy_drop", bus.busy, 1'b0);

        // ---------------- spurious m_done while idle ----------------
        s_rid = bus.rid; s_res = bus.result; s_err = bus.err;
        spurious = 1'b1;
        for (int n = 0; n < 5; n++) step();
        spurious = 1'b0;
        step();
        check("spurious_hold", {bus.rid, bus.result, bus.err, bus.busy}, {s_rid, s_res, s_err, 1'b0});

        // ---------------- reset during WAIT, late m_done ignored ----------------
        bus.req0 = 1'b1; bus.a0 = 8'd9; bus.b0 = 8'd9;
        cur_delay = 20;
        begin
            bit got;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                step();
                got = dut_ack;
            end
            if (!got) bound_fail("wait_ack_before_reset");
        end
        bus.req0 = 1'b0;
        for (int n = 0; n < 5; n++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_reset_values",
              {bus.rid, bus.result, bus.err, bus.m_a, bus.m_b, bus.busy, bus.rvalid, bus.ack0, bus.ack1, bus.m_start},
              '0);
        for (int n = 0; n < 30; n++) step();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.a0 = 8'd2; bus.b0 = 8'd3; bus.a1 = 8'd4; bus.b1 = 8'd5;
        cur_delay = 3;
        run_txn(1'b1, lat);
        check("post_abort_rid", bus.rid, 1'b0);
        check("post_abort_result", bus.result, 16'd6);
        check("post_abort_latency", lat, 5);

        // ---------------- randomized traffic against the model ----------------
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 4) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 4) == 0) bus.req1 = ~bus.req1;
            bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
            bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
            if (!inflight) begin
                case ($urandom_range(0, 11))
                    0:       cur_delay = 63;
                    1:       cur_delay = 64;
                    2:       cur_delay = 65;
                    3:       cur_delay = c_NEVER;
                    default: cur_delay = int'($urandom_range(1, 10));
                endcase
                spurious = ($urandom_range(0, 7) == 0);
            end else begin
                spurious = 1'b0;
            end
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1'b1; spurious = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int n = 0; n < 200 && inflight; n++) step();
        if (inflight) bound_fail("random_drain");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits of the shared multiplier.
REQ-002 Parameter: TIMEOUT, default 64, maximum WAIT-state cycles before abort (>= 2*WIDTH+4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 req0, req1  input  1 each  requester 0/1 wants a multiplication; level, held until ack.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands of requester 0/1, valid while its req is high.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-008 rvalid  output  1  one-cycle pulse: result/err/rid valid.
REQ-009 rid  output  1  requester ID of the completed transaction.
REQ-010 result  output  2*WIDTH  product of latched operands.
REQ-011 err  output  1  qualifies rvalid: transaction aborted by timeout, result = 0.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 m_start  output  1  one-cycle start pulse to the multiplier.
REQ-014 m_a, m_b  output  WIDTH each  latched operands, held stable from ISSUE through RESP.
REQ-015 m_done  input  1  multiplier completion pulse.
REQ-016 m_product  input  2*WIDTH  multiplier product, valid in the cycle m_done is high.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; one-hot or binary encoding is free.
REQ-018 IDLE: no req -> stay; any req -> select winner, latch its operands into m_a/m_b, latch rid, pulse its ack in the same cycle, next ISSUE.
REQ-019 Arbitration round-robin: single req wins directly; both high -> requester not granted last wins.
REQ-020 Priority pointer updates on grant (in IDLE), not on completion.
REQ-021 ISSUE: m_start=1 for exactly this cycle; clear timeout counter; next WAIT.
REQ-022 WAIT: m_done=1 -> capture m_product into result, err=0, next RESP.
REQ-023 WAIT: counter increments each cycle without m_done; on counter reaching TIMEOUT-1 with no m_done -> result=0, err=1, next RESP.
REQ-024 WAIT: m_done and timeout in same cycle -> m_done wins (err=0, product captured).
REQ-025 RESP: rvalid=1 for exactly this cycle with rid/result/err; next IDLE.
REQ-026 result, rid, err hold their values after RESP until the next RESP overwrites them.
REQ-027 m_done outside WAIT is ignored; no state or output change.
REQ-028 req deasserted before ack -> request dropped, no ack, no record.
REQ-029 req still high after its ack -> treated as a new request at next IDLE.
REQ-030 Req/operand changes after ack do not affect m_a, m_b or the in-flight transaction.
REQ-031 Minimum turnaround: IDLE->ISSUE->WAIT->RESP->IDLE, i.e. ack to rvalid = 2 + (WAIT cycles).
REQ-032 At most one ack per cycle; ack0 and ack1 never high together.

Reset
REQ-033 reset=0 at a rising edge -> state IDLE, priority pointer favours requester 0, timeout counter 0.
REQ-034 Reset values: ack0=ack1=0, rvalid=0, rid=0, result=0, err=0, busy=0, m_start=0, m_a=m_b=0.
REQ-035 Reset mid-transaction (any state) aborts it: no rvalid issued; a later m_done is ignored per REQ-027.

Verification
REQ-036 WIDTH=8; req0=1, a0=12, b0=11; multiplier model done after 10 WAIT cycles -> ack0 at grant, m_start 1 cycle later, rvalid rid=0 result=132 err=0.
REQ-037 req0, req1 both high from reset, a0=3 b0=5, a1=7 b1=9, held after acks -> grant order 0,1,0,1; results 15,63 alternate; ack0/ack1 never overlap.
REQ-038 req1 only, a1=255 b1=255 -> result=65025 rid=1; then req0 & req1 together -> req0 wins.
REQ-039 Model never asserts m_done, TIMEOUT=64 -> rvalid exactly 64 WAIT cycles after entering WAIT, err=1, result=0, busy drops next cycle.
REQ-040 m_done coincident with final timeout cycle -> err=0, product delivered; spurious m_done in IDLE -> no output change.
REQ-041 reset=0 asserted in WAIT, then model asserts m_done -> no rvalid, all outputs at reset values, next req0 granted normally.
